wb_arbiter2: RTL and testbench
==============================

# wb_arbiter2

Two-master Wishbone B4 classic arbiter that lets a second bus master share the single master port of `wb_intercon` with the core's data-side `wishbone_controller`. Master 0 is the core data port; master 1 is a secondary master such as the planned UART boot loader or a DMA engine. The arbiter grants one master per bus tenure, using round-robin priority when both request. It also runs a watchdog that terminates stalled strobes with an error, so a missing slave cannot hang the pipeline.

## Interface
Parameters
- `TIMEOUT`, default 255: number of consecutive unacknowledged strobe cycles before the arbiter returns an error. 0 disables the watchdog.
- `AW`, default 32: address width.
- `DW`, default 32: data width. `SEL` width is `DW/8`.

Ports
- `wb_clk_i`  in  1  Single clock.
- `wb_rst_i`  in  1  Reset. Synchronous and active-high.
- `m0_adr_i`, `m1_adr_i`  in  AW  Master address.
- `m0_dat_i`, `m1_dat_i`  in  DW  Master write data.
- `m0_sel_i`, `m1_sel_i`  in  DW/8  Byte selects.
- `m0_we_i`, `m1_we_i`  in  1  Write enable.
- `m0_cyc_i`, `m1_cyc_i`  in  1  Cycle request. Doubles as the tenure lock.
- `m0_stb_i`, `m1_stb_i`  in  1  Strobe.
- `m0_dat_o`, `m1_dat_o`  out  DW  Read data. Both are driven by `s_dat_i`.
- `m0_ack_o`, `m1_ack_o`  out  1  Acknowledge. Asserted only toward the granted master.
- `m0_err_o`, `m1_err_o`  out  1  Error. Comes from the slave error or the watchdog.
- `s_adr_o`  out  AW  Address toward the interconnect.
- `s_dat_o`  out  DW  Write data toward the interconnect.
- `s_sel_o`  out  DW/8  Byte selects toward the interconnect.
- `s_we_o`  out  1  Write enable toward the interconnect.
- `s_cyc_o`  out  1  Cycle toward the interconnect.
- `s_stb_o`  out  1  Strobe toward the interconnect.
- `s_dat_i`  in  DW  Read data from the interconnect.
- `s_ack_i`  in  1  Acknowledge from the interconnect.
- `s_err_i`  in  1  Error from the interconnect.
- `grant_o`  out  2  One-hot current grant. Value `2'b00` when idle.

## Operation
- The FSM has three states: IDLE, BUS_M0, BUS_M1. A `last_grant` register holds the most recently granted master. A watchdog counter `wd_cnt` has width `$clog2(TIMEOUT+1)`.
- In IDLE:
  - Only `m0_cyc_i` high: go to BUS_M0.
  - Only `m1_cyc_i` high: go to BUS_M1.
  - Both high: grant the master that is not `last_grant`.
  - Neither high: stay in IDLE.
- In BUS_Mx:
  - All `s_*` outputs mirror master x combinationally.
  - `s_ack_i` and `s_err_i` are routed to master x only. The other master sees `ack = 0` and `err = 0`.
  - The FSM stays in BUS_Mx while `mx_cyc_i = 1`. This keeps multi-transfer tenures locked.
- When `mx_cyc_i` drops:
  - If the other master's `cyc` is high, go directly to BUS_other with no idle cycle.
  - Otherwise go to IDLE.
- `last_grant` updates on every entry to a BUS state.
- In IDLE:
  - `s_cyc_o`, `s_stb_o`, `s_we_o` are 0.
  - `s_adr_o`, `s_dat_o`, `s_sel_o` are 0.
  - All master acks and errors are 0.
- Watchdog counter:
  - It increments each cycle in a BUS state with `s_stb_o = 1` and `s_ack_i = 0` and `s_err_i = 0`.
  - It clears on `s_ack_i`, on `s_err_i`, on `s_stb_o = 0`, on any state change, and after it fires.
- Watchdog firing:
  - `mx_err_o` is asserted combinationally in the TIMEOUT-th consecutive unacknowledged strobe cycle, when `wd_cnt == TIMEOUT-1`.
  - If `s_ack_i` arrives in that same cycle, the ack wins and no error is generated.
- After a watchdog error, the master is responsible for dropping `stb`/`cyc`. A late slave ack that arrives after the master has dropped `cyc` is discarded.
- Reset values: state IDLE, `last_grant = 1` (so m0 wins the first contested arbitration), `wd_cnt = 0`, `grant_o = 2'b00`. Every `s_*` and `m*` output is 0.

## Timing
- Arbitration latency is one cycle. A request first seen in IDLE at edge N gets its grant, and the `s_cyc_o`/`s_stb_o` drive, from cycle N+1.
- There are no combinational paths from `mx_cyc_i` to `grant_o`, because the grant is registered.
- The data path is combinational: `s_ack_i` produces `mx_ack_o` in the same cycle.
- Handover: if master x drops `cyc` at edge N and the other master is requesting, the other master owns the bus from cycle N+1. There is a single-cycle gap at most.
- If `wb_rst_i` is asserted mid-tenure, the arbiter is in IDLE on the next edge with all outputs 0. The in-flight slave transfer is abandoned.

## Test plan
- **Single read.** m0 requests with `cyc`/`stb` and `adr = 0x2000_0000` at cycle 0. Required: `grant_o = 01` at cycle 1. The slave acks at cycle 3 with `0xDEADBEEF`, giving `m0_ack_o = 1` and `m0_dat_o = 0xDEADBEEF` at cycle 3, with `m1_ack_o = 0` throughout.
- **Round robin.** Both masters request continuously over four tenures of one transfer each. Required: grants go m0, m1, m0, m1, with a handover within one cycle of each `cyc` drop.
- **Locked tenure.** m0 holds `cyc` across three acked transfers while m1 requests. Required: `grant_o` stays `01` until m0 drops `cyc`, then becomes `10` on the next cycle.
- **Timeout.** With `TIMEOUT = 8`, m1 strobes and the slave never acks. Required: `m1_err_o` pulses only in the 8th strobe cycle and `m1_ack_o` stays 0. When m1 drops `cyc`, the FSM returns to IDLE.
- **Ack/timeout collision.** With `TIMEOUT = 8`, the slave acks exactly in the 8th strobe cycle. Required: `ack = 1`, `err = 0`, and the counter is cleared.
- **Reset mid-tenure.** Assert `wb_rst_i` during BUS_M1. Required: next cycle shows `s_cyc_o = 0` and `grant_o = 00`. After release with both masters requesting, m0 is granted.

Source files
------------

// File: rtl/wb_arbiter2.sv
// Two-master Wishbone B4 classic arbiter with round-robin grant, cyc-locked tenures
// and a strobe watchdog that errors out stalled transfers.
module wb_arbiter2 #(
   parameter int unsigned TIMEOUT = 255,
   parameter int unsigned AW      = 32,
   parameter int unsigned DW      = 32
) (
   input  logic            wb_clk_i,
   input  logic            wb_rst_i,
   input  logic [AW-1:0]   m0_adr_i,
   input  logic [DW-1:0]   m0_dat_i,
   input  logic [DW/8-1:0] m0_sel_i,
   input  logic            m0_we_i,
   input  logic            m0_cyc_i,
   input  logic            m0_stb_i,
   output logic [DW-1:0]   m0_dat_o,
   output logic            m0_ack_o,
   output logic            m0_err_o,
   input  logic [AW-1:0]   m1_adr_i,
   input  logic [DW-1:0]   m1_dat_i,
   input  logic [DW/8-1:0] m1_sel_i,
   input  logic            m1_we_i,
   input  logic            m1_cyc_i,
   input  logic            m1_stb_i,
   output logic [DW-1:0]   m1_dat_o,
   output logic            m1_ack_o,
   output logic            m1_err_o,
   output logic [AW-1:0]   s_adr_o,
   output logic [DW-1:0]   s_dat_o,
   output logic [DW/8-1:0] s_sel_o,
   output logic            s_we_o,
   output logic            s_cyc_o,
   output logic            s_stb_o,
   input  logic [DW-1:0]   s_dat_i,
   input  logic            s_ack_i,
   input  logic            s_err_i,
   output logic [1:0]      grant_o
);

   localparam int unsigned WW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [WW-1:0] WdLast = WW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   typedef enum logic [1:0] {StIdle, StBusM0, StBusM1} state_e;

   state_e        state_q, state_d;
   logic          last_grant_q, last_grant_d;
   logic [WW-1:0] wd_cnt_q, wd_cnt_d;
   logic          own_stb;
   logic          wd_fire;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (m0_cyc_i && m1_cyc_i) state_d = last_grant_q ? StBusM0 : StBusM1;
            else if (m0_cyc_i)        state_d = StBusM0;
            else if (m1_cyc_i)        state_d = StBusM1;
         end
         StBusM0: if (!m0_cyc_i) state_d = m1_cyc_i ? StBusM1 : StIdle;
         StBusM1: if (!m1_cyc_i) state_d = m0_cyc_i ? StBusM0 : StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      last_grant_d = last_grant_q;
      if (state_d == StBusM0 && state_q != StBusM0) last_grant_d = 1'b0;
      if (state_d == StBusM1 && state_q != StBusM1) last_grant_d = 1'b1;
   end

   assign own_stb = (state_q == StBusM0) ? m0_stb_i :
                    (state_q == StBusM1) ? m1_stb_i : 1'b0;

   // A same-cycle ack (or slave error) beats the watchdog.
   assign wd_fire = (TIMEOUT != 0) && own_stb && !s_ack_i && !s_err_i && (wd_cnt_q == WdLast);

   always_comb begin
      wd_cnt_d = wd_cnt_q + 1'b1;
      if ((TIMEOUT == 0) || (state_d != state_q) || !own_stb || s_ack_i || s_err_i || wd_fire) begin
         wd_cnt_d = '0;
      end
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_q      <= StIdle;
         last_grant_q <= 1'b1;
         wd_cnt_q     <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         wd_cnt_q     <= wd_cnt_d;
      end
   end

   assign grant_o = {state_q == StBusM1, state_q == StBusM0};

   // Responses are gated by the owner's cyc so a late ack after cyc drops is discarded.
   always_comb begin
      s_adr_o  = '0;
      s_dat_o  = '0;
      s_sel_o  = '0;
      s_we_o   = 1'b0;
      s_cyc_o  = 1'b0;
      s_stb_o  = 1'b0;
      m0_ack_o = 1'b0;
      m0_err_o = 1'b0;
      m1_ack_o = 1'b0;
      m1_err_o = 1'b0;
      m0_dat_o = s_dat_i;
      m1_dat_o = s_dat_i;
      unique case (state_q)
         StBusM0: begin
            s_adr_o  = m0_adr_i;
            s_dat_o  = m0_dat_i;
            s_sel_o  = m0_sel_i;
            s_we_o   = m0_we_i;
            s_cyc_o  = m0_cyc_i;
            s_stb_o  = m0_stb_i;
            m0_ack_o = m0_cyc_i & s_ack_i;
            m0_err_o = m0_cyc_i & (s_err_i | wd_fire);
         end
         StBusM1: begin
            s_adr_o  = m1_adr_i;
            s_dat_o  = m1_dat_i;
            s_sel_o  = m1_sel_i;
            s_we_o   = m1_we_i;
            s_cyc_o  = m1_cyc_i;
            s_stb_o  = m1_stb_i;
            m1_ack_o = m1_cyc_i & s_ack_i;
            m1_err_o = m1_cyc_i & (s_err_i | wd_fire);
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_wb_arbiter2.sv
// Directed bench for wb_arbiter2: a per-cycle vector table plus hand sequences for
// locked tenure, watchdog timeout, ack/timeout collision and reset mid-tenure.
module tb_wb_arbiter2;

   localparam logic [31:0] A0 = 32'h2000_0000;
   localparam logic [31:0] A1 = 32'h3000_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] m0_adr, m0_dat, m1_adr, m1_dat, m0_rdat, m1_rdat;
   logic [3:0]  m0_sel, m1_sel, s_sel;
   logic        m0_we, m0_cyc, m0_stb, m0_ack, m0_err;
   logic        m1_we, m1_cyc, m1_stb, m1_ack, m1_err;
   logic [31:0] s_adr, s_wdat, s_rdat;
   logic        s_we, s_cyc, s_stb, s_ack, s_err;
   logic [1:0]  grant;

   always #5 clk = ~clk;

   wb_arbiter2 #(.TIMEOUT(8), .AW(32), .DW(32)) dut (
      .wb_clk_i(clk), .wb_rst_i(rst),
      .m0_adr_i(m0_adr), .m0_dat_i(m0_dat), .m0_sel_i(m0_sel), .m0_we_i(m0_we),
      .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_dat_o(m0_rdat), .m0_ack_o(m0_ack),
      .m0_err_o(m0_err),
      .m1_adr_i(m1_adr), .m1_dat_i(m1_dat), .m1_sel_i(m1_sel), .m1_we_i(m1_we),
      .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_dat_o(m1_rdat), .m1_ack_o(m1_ack),
      .m1_err_o(m1_err),
      .s_adr_o(s_adr), .s_dat_o(s_wdat), .s_sel_o(s_sel), .s_we_o(s_we),
      .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_dat_i(s_rdat), .s_ack_i(s_ack),
      .s_err_i(s_err), .grant_o(grant)
   );

   typedef struct {
      logic        m0c, m0s, m1c, m1s, ack, err;
      logic [31:0] sdat;
      logic [1:0]  gnt;
      logic        scyc, sstb, a0, a1, e0, e1;
      logic [31:0] sadr;
   } vec_t;

   vec_t vecs[$];
   int   checks   = 0;
   int   failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic c0, s0, c1, s1, ack, err, input logic [31:0] sdat);
      m0_cyc = c0; m0_stb = s0; m1_cyc = c1; m1_stb = s1;
      s_ack = ack; s_err = err; s_rdat = sdat;
   endtask

   task automatic add(input logic c0, s0, c1, s1, ack, err, input logic [31:0] sdat,
                      input logic [1:0] gnt, input logic scyc, sstb, a0, a1, e0, e1,
                      input logic [31:0] sadr);
      vec_t v;
      v = '{c0, s0, c1, s1, ack, err, sdat, gnt, scyc, sstb, a0, a1, e0, e1, sadr};
      vecs.push_back(v);
   endtask

   initial begin
      // Round robin over four single-transfer tenures, starting from reset
      add(1,1,1,1,0,0,32'h0,         2'b00,0,0,0,0,0,0,32'h0);
      add(1,1,1,1,1,0,32'h1111_0001, 2'b01,1,1,1,0,0,0,A0);
      add(0,0,1,1,0,0,32'h0,         2'b01,0,0,0,0,0,0,A0);
      add(1,1,1,1,1,0,32'h0000_0002, 2'b10,1,1,0,1,0,0,A1);
      add(1,1,0,0,0,0,32'h0,         2'b10,0,0,0,0,0,0,A1);
      add(1,1,1,1,1,0,32'h0000_0003, 2'b01,1,1,1,0,0,0,A0);
      add(0,0,1,1,0,0,32'h0,         2'b01,0,0,0,0,0,0,A0);
      add(0,0,1,1,1,0,32'h0000_0004, 2'b10,1,1,0,1,0,0,A1);
      add(0,0,0,0,0,0,32'h0,         2'b10,0,0,0,0,0,0,A1);
      add(0,0,0,0,1,0,32'h0000_0005, 2'b00,0,0,0,0,0,0,32'h0);
      // Single read by m0, slave error routing, late ack after cyc drop
      add(1,1,0,0,0,0,32'h0,         2'b00,0,0,0,0,0,0,32'h0);
      add(1,1,0,0,0,0,32'h0,         2'b01,1,1,0,0,0,0,A0);
      add(1,1,0,0,0,1,32'h0,         2'b01,1,1,0,0,1,0,A0);
      add(1,1,0,0,1,0,32'hDEAD_BEEF, 2'b01,1,1,1,0,0,0,A0);
      add(0,0,0,0,1,0,32'h0000_0006, 2'b01,0,0,0,0,0,0,A0);
      add(0,0,0,0,0,0,32'h0,         2'b00,0,0,0,0,0,0,32'h0);

      m0_adr = A0; m0_dat = 32'h1111_1111; m0_sel = 4'hF; m0_we = 1'b1;
      m1_adr = A1; m1_dat = 32'h2222_2222; m1_sel = 4'h3; m1_we = 1'b0;

      // Reset with m0 requesting: arbiter must stay idle with all outputs low
      rst = 1'b1;
      drive(1, 1, 0, 0, 0, 0, 32'h0);
      repeat (2) @(negedge clk);
      #1;
      chk("reset grant", 32'(grant), 32'h0);
      chk("reset s_cyc", 32'(s_cyc), 32'h0);
      chk("reset s_stb", 32'(s_stb), 32'h0);
      chk("reset s_adr", s_adr, 32'h0);
      chk("reset s_dat", s_wdat, 32'h0);
      chk("reset s_we",  32'(s_we), 32'h0);
      @(negedge clk);
      rst = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 32'h0);

      foreach (vecs[i]) begin
         @(negedge clk);
         drive(vecs[i].m0c, vecs[i].m0s, vecs[i].m1c, vecs[i].m1s, vecs[i].ack, vecs[i].err,
               vecs[i].sdat);
         #1;
         chk($sformatf("row%0d grant", i),   32'(grant),  32'(vecs[i].gnt));
         chk($sformatf("row%0d s_cyc", i),   32'(s_cyc),  32'(vecs[i].scyc));
         chk($sformatf("row%0d s_stb", i),   32'(s_stb),  32'(vecs[i].sstb));
         chk($sformatf("row%0d m0_ack", i),  32'(m0_ack), 32'(vecs[i].a0));
         chk($sformatf("row%0d m1_ack", i),  32'(m1_ack), 32'(vecs[i].a1));
         chk($sformatf("row%0d m0_err", i),  32'(m0_err), 32'(vecs[i].e0));
         chk($sformatf("row%0d m1_err", i),  32'(m1_err), 32'(vecs[i].e1));
         chk($sformatf("row%0d s_adr", i),   s_adr,       vecs[i].sadr);
         chk($sformatf("row%0d m0_dat", i),  m0_rdat,     vecs[i].sdat);
         chk($sformatf("row%0d m1_dat", i),  m1_rdat,     vecs[i].sdat);
      end

      // Locked tenure: m0 holds cyc over three acked transfers while m1 waits
      @(negedge clk); drive(1, 1, 0, 0, 0, 0, 32'h0); #1;
      chk("lock idle grant", 32'(grant), 32'h0);
      @(negedge clk); drive(1, 1, 1, 1, 0, 0, 32'h0); #1;
      chk("lock first grant", 32'(grant), 32'h1);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk); drive(1, 1, 1, 1, 1, 0, 32'h0); #1;
         chk($sformatf("lock%0d m0_ack", k), 32'(m0_ack), 32'h1);
         chk($sformatf("lock%0d m1_ack", k), 32'(m1_ack), 32'h0);
         chk($sformatf("lock%0d grant", k),  32'(grant),  32'h1);
         chk($sformatf("lock%0d s_dat", k),  s_wdat,      32'h1111_1111);
         chk($sformatf("lock%0d s_sel", k),  32'(s_sel),  32'hF);
         chk($sformatf("lock%0d s_we", k),   32'(s_we),   32'h1);
         @(negedge clk); drive(1, 1, 1, 1, 0, 0, 32'h0); #1;
         chk($sformatf("lock%0d hold grant", k), 32'(grant), 32'h1);
      end
      @(negedge clk); drive(0, 0, 1, 1, 0, 0, 32'h0); #1;
      chk("lock drop grant", 32'(grant), 32'h1);
      chk("lock drop s_cyc", 32'(s_cyc), 32'h0);

      // First m1 cycle is strobe cycle 1 of the timeout run
      @(negedge clk); #1;
      chk("handover grant", 32'(grant), 32'h2);
      chk("handover s_adr", s_adr, A1);
      chk("handover s_sel", 32'(s_sel), 32'h3);
      chk("handover s_we",  32'(s_we), 32'h0);
      chk("timeout cyc1 err", 32'(m1_err), 32'h0);
      for (int i = 2; i <= 8; i++) begin
         @(negedge clk); #1;
         chk($sformatf("timeout cyc%0d m1_err", i), 32'(m1_err), 32'(i == 8));
         chk($sformatf("timeout cyc%0d m1_ack", i), 32'(m1_ack), 32'h0);
         chk($sformatf("timeout cyc%0d m0_err", i), 32'(m0_err), 32'h0);
      end
      @(negedge clk); #1;
      chk("timeout after-fire err", 32'(m1_err), 32'h0);
      @(negedge clk); drive(0, 0, 0, 0, 0, 0, 32'h0); #1;
      chk("timeout drop grant", 32'(grant), 32'h2);
      chk("timeout drop err", 32'(m1_err), 32'h0);
      @(negedge clk); #1;
      chk("timeout idle grant", 32'(grant), 32'h0);

      // Ack arriving in the 8th strobe cycle beats the watchdog and clears it
      @(negedge clk); drive(0, 0, 1, 1, 0, 0, 32'h0); #1;
      chk("collide idle grant", 32'(grant), 32'h0);
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk); drive(0, 0, 1, 1, i == 8, 0, 32'h0); #1;
         chk($sformatf("collide cyc%0d m1_err", i), 32'(m1_err), 32'h0);
         chk($sformatf("collide cyc%0d m1_ack", i), 32'(m1_ack), 32'(i == 8));
      end
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk); drive(0, 0, 1, 1, 0, 0, 32'h0); #1;
         chk($sformatf("recount cyc%0d m1_err", i), 32'(m1_err), 32'(i == 8));
      end
      @(negedge clk); drive(0, 0, 0, 0, 0, 0, 32'h0);
      @(negedge clk); #1;
      chk("collide idle", 32'(grant), 32'h0);

      // Reset during an m1 tenure, then contested request goes to m0
      @(negedge clk); drive(0, 0, 1, 1, 0, 0, 32'h0); #1;
      chk("rst pre grant", 32'(grant), 32'h0);
      @(negedge clk); #1;
      chk("rst m1 grant", 32'(grant), 32'h2);
      chk("rst m1 s_cyc", 32'(s_cyc), 32'h1);
      @(negedge clk); rst = 1'b1; drive(1, 1, 1, 1, 0, 0, 32'h0);
      @(negedge clk); rst = 1'b0; #1;
      chk("rst s_cyc", 32'(s_cyc), 32'h0);
      chk("rst grant", 32'(grant), 32'h0);
      chk("rst s_adr", s_adr, 32'h0);
      @(negedge clk); #1;
      chk("rst rearb grant", 32'(grant), 32'h1);
      drive(0, 0, 0, 0, 0, 0, 32'h0);
      repeat (2) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
